flex_timer: RTL
===============

# flex_timer

Parametrised prescaled up/down counter with programmable terminal value, selectable wrap, saturate or one-shot mode, synchronous load, and level and pulse terminal indications. It is the general-purpose timing and event-count primitive for the team's peripherals: baud and bit timing, timeouts, and PWM periods. It sits directly behind register-mapped control fields, so every control input may change on any cycle.

## Interface
- NUM_CNT_BITS, 8, width of main counter, load_val and rollover_val
- NUM_PRE_BITS, 4, width of prescaler and prescale_val
- clk  input  1  clock, all state on rising edge
- nrst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of counter, prescaler, done, pulse
- count_enable  input  1  advances prescaler; gates ticks
- up_down  input  1  1 = count up, 0 = count down
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- load  input  1  synchronous load of load_val
- load_val  input  NUM_CNT_BITS  value loaded on load
- rollover_val  input  NUM_CNT_BITS  upper terminal value
- prescale_val  input  NUM_PRE_BITS  tick every prescale_val+1 enabled cycles
- count_out  output  NUM_CNT_BITS  registered count
- rollover_flag  output  1  registered, high while count_out is at the active terminal
- rollover_pulse  output  1  registered, one-cycle pulse per terminal event
- done  output  1  registered, sticky one-shot completion

## Operation
- Reset (nrst low, async): count_out, prescaler, rollover_flag, rollover_pulse and done are all 0.
- Priority per cycle: clear > load > tick > hold.
- clear: count 0, prescaler 0, done 0, pulse 0.
- load: count = load_val, prescaler 0, done 0, pulse 0. A load does not generate a terminal event.
- Prescaler:
  - Counts 0..prescale_val only while count_enable = 1; freezes otherwise.
  - tick = count_enable && prescaler == prescale_val; the prescaler returns to 0 on tick.
  - prescale_val = 0 gives a tick on every enabled cycle.
- Terminal value: up_down = 1 → rollover_val; up_down = 0 → 0.
- On tick, when not at terminal: up adds 1, down subtracts 1.
- On tick, when at terminal (terminal event):
  - wrap: up → 0, down → rollover_val.
  - saturate: hold.
  - one-shot: hold, and set done.
- While done = 1, ticks are ignored and the prescaler holds.
- Up count above rollover_val (after a load or a rollover_val change) is treated as at terminal. In wrap mode it goes to 0 on the next tick.
- rollover_val == 0:
  - Count forced to 0 on each tick.
  - rollover_flag, rollover_pulse and done are never set.
- rollover_flag = (next_count == active terminal) && rollover_val != 0, registered so it aligns with count_out.
- rollover_pulse is high for exactly the cycle after each terminal event. In saturate mode it repeats on every tick while held.
- All arithmetic is modulo 2^NUM_CNT_BITS. up_down and mode changes take effect on the next tick, with no restart.

## Timing
- One register stage. count_out changes on the clock edge of the tick cycle.
- First count change after enable: prescale_val+1 enabled cycles.
- clear and load take effect on the next edge, regardless of count_enable.
- Simultaneous clear and load: clear wins. Simultaneous load and tick: load wins, and the tick is discarded.
- rollover_pulse and done rise on the same edge that follows the terminal event.
- Asserting nrst mid-count zeroes all outputs immediately, without waiting for a clock edge.

## Structure
- The package flex_timer_pkg holds:
  - typedef enum logic [1:0] timer_mode_t: MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD.
- Sub-module tick_prescaler:
  - Parameter NUM_PRE_BITS.
  - Inputs: clk, nrst, clear (driven by clear | load), enable (count_enable && !done), prescale_val.
  - Output: tick.
- The top level holds the counter, flag, pulse and done registers and the next-state logic.

## Test plan
- NUM_CNT_BITS = 8, prescale_val = 0, wrap, up, rollover_val = 3, enable held:
  - count_out 0,1,2,3,0,1.
  - rollover_flag high only while count_out = 3.
  - pulse high for one cycle with count_out = 0.
- prescale_val = 2, up, rollover_val = 10: count_out increments every 3rd enabled cycle. Dropping count_enable for 5 cycles freezes both count and prescaler.
- Down, wrap, load_val = 2, rollover_val = 5:
  - count_out 2,1,0,5,4.
  - flag high at 0; pulse high for one cycle with count_out = 5.
- Saturate, up, rollover_val = 4:
  - Count holds at 4 and flag stays high.
  - pulse asserts on every tick while held.
- One-shot, down, load_val = 3:
  - Sequence 3,2,1,0; done rises one cycle after the tick taken at 0, and the count stays 0.
  - Further ticks are ignored; load clears done.
- Priority: clear + load + tick in the same cycle → count 0.
- Reset: nrst pulsed low mid-count → all outputs 0 asynchronously.
- rollover_val = 0: count stays 0 and no flag, pulse or done is ever set.

Source files
------------

// File: rtl/flex_timer_pkg.sv
// flex_timer_pkg: shared types for the flex_timer counter block
package flex_timer_pkg;
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } timer_mode_t;
endpackage

// File: rtl/flex_timer_tick_prescaler.sv
// tick_prescaler: emits one tick every prescale_val+1 enabled cycles
module tick_prescaler #(
  parameter int NUM_PRE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [NUM_PRE_BITS-1:0] prescale_val,
  output logic                    tick
);
  logic [NUM_PRE_BITS-1:0] r_cnt;
  assign tick = enable && (r_cnt == prescale_val);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (enable) r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/flex_timer.sv
// flex_timer: prescaled up/down counter with wrap, saturate and one-shot modes
module flex_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_PRE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    up_down,
  input  logic [1:0]              mode,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_PRE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_pulse,
  output logic                    done
);
  logic [NUM_CNT_BITS-1:0] r_count, w_next, w_step, w_term_val, w_tick_val;
  logic r_flag, r_pulse, r_done;
  logic w_tick, w_rv_zero, w_at_term, w_event, w_wrap, w_restart;
  timer_mode_t w_mode;
  tick_prescaler #(.NUM_PRE_BITS(NUM_PRE_BITS)) u_pre (
    .clk(clk),
    .nrst(nrst),
    .clear(clear | load),
    .enable(count_enable && !r_done),
    .prescale_val(prescale_val),
    .tick(w_tick)
  );
  assign w_mode     = timer_mode_t'(mode);
  assign w_wrap     = (w_mode == MODE_WRAP) || (w_mode == MODE_RSVD);
  assign w_rv_zero  = (rollover_val == '0);
  assign w_restart  = clear | load;
  // an up count beyond rollover_val counts as sitting at the terminal
  assign w_at_term  = up_down ? (r_count >= rollover_val) : (r_count == '0);
  assign w_event    = w_tick && w_at_term && !w_rv_zero;
  assign w_term_val = up_down ? rollover_val : '0;
  assign w_step     = up_down ? r_count + 1'b1 : r_count - 1'b1;
  assign w_tick_val = w_rv_zero ? '0 :
                      !w_at_term ? w_step :
                      w_wrap ? (up_down ? '0 : rollover_val) : r_count;
  assign w_next     = clear ? '0 : load ? load_val : w_tick ? w_tick_val : r_count;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_flag  <= (w_next == w_term_val) && !w_rv_zero;
      r_pulse <= !w_restart && w_event;
      r_done  <= !w_restart && (r_done || (w_event && w_mode == MODE_ONESHOT));
    end
  end
  assign count_out      = r_count;
  assign rollover_flag  = r_flag;
  assign rollover_pulse = r_pulse;
  assign done           = r_done;
endmodule
